// File: rtl/data_sync_src_pkg.sv
// Shared definitions for the multi-bit data synchronizer source side.
// The destination synchronizer uses the same chain depth.
package data_sync_src_pkg;

    localparam int unsigned DEF_NUM_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REQ      = 2'b01,
        WAIT_LOW = 2'b10
    } state_e;

endpackage

// File: rtl/data_sync_src_bit_sync.sv
// Single-bit flop-chain synchronizer, synchronous active-high reset to 0.
// Used for the returned ack level from the destination domain.
module bit_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic dout
);

    logic [NUM_STAGES-1:0] chain;

    always_ff @(posedge CLK) begin
        if (RST) begin
            chain <= '0;
        end else begin
            chain <= {chain[NUM_STAGES-2:0], din};
        end
    end

    assign dout = chain[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_src.sv
// Source-domain launcher: holds a word on unsync_bus and runs a 4-phase
// level handshake against the destination's returned enable.
module data_sync_src
    import data_sync_src_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int BUS_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] src_data,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic                 ack_async,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    output logic                 busy,
    output logic                 proto_err,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    state_e               state;
    logic                 ack_sync;
    logic                 pend_vld;
    logic [BUS_WIDTH-1:0] pend_data;
    logic                 accept;
    logic                 bypass;

    bit_sync #(
        .NUM_STAGES(NUM_STAGES)
    ) u_ack_sync (
        .CLK (CLK),
        .RST (RST),
        .din (ack_async),
        .dout(ack_sync)
    );

    assign src_ready = !pend_vld;
    assign accept    = src_valid & src_ready;
    assign busy      = (state != IDLE);
    // An accepted word goes straight to the bus only when IDLE can launch it.
    assign bypass    = (state == IDLE) && !ack_sync;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            bus_enable <= 1'b0;
            unsync_bus <= '0;
            pend_vld   <= 1'b0;
            pend_data  <= '0;
            proto_err  <= 1'b0;
            xfer_count <= '0;
        end else begin
            if (accept && !bypass) begin
                pend_vld  <= 1'b1;
                pend_data <= src_data;
            end
            case (state)
                IDLE: begin
                    if (ack_sync) begin
                        proto_err <= 1'b1;
                    end else if (pend_vld) begin
                        unsync_bus <= pend_data;
                        pend_vld   <= 1'b0;
                        bus_enable <= 1'b1;
                        state      <= REQ;
                    end else if (accept) begin
                        unsync_bus <= src_data;
                        bus_enable <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (ack_sync) begin
                        bus_enable <= 1'b0;
                        state      <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!ack_sync) begin
                        xfer_count <= xfer_count + CNT_WIDTH'(1);
                        state      <= IDLE;
                    end
                end
                default: begin
                    bus_enable <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sync_src.sv
// Directed + randomized bench for data_sync_src with a 2-flop
// destination-clock ack loop and a queue-based word model.
module tb_data_sync_src;

    localparam int NS = 2;
    localparam int BW = 8;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          dclk = 1'b0;
    logic          RST;
    logic [BW-1:0] src_data;
    logic          src_valid;
    logic          src_ready;
    logic          ack_async;
    logic [BW-1:0] unsync_bus;
    logic          bus_enable;
    logic          busy;
    logic          proto_err;
    logic [CW-1:0] xfer_count;

    logic          force_ack;
    logic          d1 = 1'b0;
    logic          d2 = 1'b0;

    int            compared   = 0;
    int            mismatched = 0;
    int            n_acc      = 0;
    logic [BW-1:0] exp_q[$];

    data_sync_src #(
        .NUM_STAGES(NS),
        .BUS_WIDTH (BW),
        .CNT_WIDTH (CW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .ack_async (ack_async),
        .unsync_bus(unsync_bus),
        .bus_enable(bus_enable),
        .busy      (busy),
        .proto_err (proto_err),
        .xfer_count(xfer_count)
    );

    always #5 CLK = ~CLK;
    always #7 dclk = ~dclk;

    // Destination side: enable level through two dest-clock flops.
    always @(posedge dclk) begin
        if (RST) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            d1 <= bus_enable;
            d2 <= d1;
        end
    end

    assign ack_async = force_ack | d2;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [BW-1:0] d);
        int n;
        n = 0;
        src_data  = d;
        src_valid = 1'b1;
        while (src_ready !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        chk("send_ready_timeout", 32'(n < 200), 32'd1);
        if (n < 200) begin
            tick(1);
            exp_q.push_back(d);
            n_acc++;
        end
        src_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (!(busy === 1'b0 && src_ready === 1'b1) && n < 500) begin
            tick(1);
            n++;
        end
        chk({tag, "_drain_timeout"}, 32'(n < 500), 32'd1);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_xfer_count"}, 32'(xfer_count), 32'(n_acc % (1 << CW)));
    endtask

    // Bus monitor: word order, bus stability, enable low gap.
    initial begin : monitor
        logic          prev_en;
        logic          seen_fall;
        int            gap;
        logic [BW-1:0] held;
        logic [BW-1:0] exp;
        prev_en   = 1'b0;
        seen_fall = 1'b0;
        gap       = 0;
        held      = '0;
        forever begin
            @(negedge CLK);
            if (RST !== 1'b0) begin
                prev_en   = 1'b0;
                seen_fall = 1'b0;
                gap       = 0;
            end else begin
                if (bus_enable && !prev_en) begin
                    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                    chk("launch_word", 32'(unsync_bus), 32'(exp));
                    if (seen_fall) begin
                        chk("enable_gap", 32'(gap >= NS + 2), 32'd1);
                    end
                    held = unsync_bus;
                end else if (busy) begin
                    chk("bus_stable", 32'(unsync_bus), 32'(held));
                end
                if (!bus_enable && prev_en) begin
                    seen_fall = 1'b1;
                    gap       = 0;
                end
                if (!bus_enable) gap++;
                prev_en = bus_enable;
            end
        end
    end

    initial begin
        RST       = 1'b1;
        src_valid = 1'b0;
        src_data  = '0;
        force_ack = 1'b0;

        // 1. reset
        tick(3);
        RST = 1'b0;
        chk("rst_bus_enable", 32'(bus_enable), 32'd0);
        chk("rst_unsync_bus", 32'(unsync_bus), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        chk("rst_xfer_count", 32'(xfer_count), 32'd0);
        chk("rst_src_ready", 32'(src_ready), 32'd1);
        tick(2);

        // 2. single word from IDLE
        send(8'hA5);
        chk("a5_enable", 32'(bus_enable), 32'd1);
        chk("a5_bus", 32'(unsync_bus), 32'hA5);
        drain("a5");

        // 3. back-to-back with pending word, third stalls
        send(8'h3C);
        send(8'hC3);
        chk("pend_full_ready", 32'(src_ready), 32'd0);
        chk("pend_bus_first", 32'(unsync_bus), 32'h3C);
        src_data  = 8'h5A;
        src_valid = 1'b1;
        tick(1);
        chk("third_stall_ready", 32'(src_ready), 32'd0);
        chk("third_stall_bus", 32'(unsync_bus), 32'h3C);
        send(8'h5A);
        drain("b2b");

        // 4. ack high while IDLE
        force_ack = 1'b1;
        tick(NS + 2);
        chk("perr_set", 32'(proto_err), 32'd1);
        chk("perr_idle", 32'(busy), 32'd0);
        chk("perr_no_enable", 32'(bus_enable), 32'd0);
        force_ack = 1'b0;
        tick(NS + 2);
        send(8'($urandom));
        drain("perr_xfer");
        chk("perr_sticky", 32'(proto_err), 32'd1);

        // 5. reset during REQ with pend full
        send(8'h11);
        send(8'h22);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_enable", 32'(bus_enable), 32'd1);
        chk("mid_pend_full", 32'(src_ready), 32'd0);
        RST = 1'b1;
        exp_q.delete();
        n_acc = 0;
        tick(1);
        chk("mrst_enable", 32'(bus_enable), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ready", 32'(src_ready), 32'd1);
        chk("mrst_perr", 32'(proto_err), 32'd0);
        chk("mrst_count", 32'(xfer_count), 32'd0);
        chk("mrst_bus", 32'(unsync_bus), 32'd0);
        tick(1);
        RST = 1'b0;
        tick(10);
        chk("mrst_no_relaunch", 32'(bus_enable), 32'd0);

        // 6. random words, counter reaches all-ones then wraps
        for (int i = 0; i < 16; i++) begin
            tick($urandom_range(0, 2));
            send(8'($urandom));
            if (i == 14) begin
                drain("wrap_pre");
                chk("count_all_ones", 32'(xfer_count), 32'hF);
            end
        end
        drain("wrap");
        chk("count_wrapped", 32'(xfer_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
